// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and constants for the elevator request path
package elevator_pkg;

   localparam int FLOOR_W = 3;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef struct packed {
      logic [FLOOR_W-1:0] src;
      logic [FLOOR_W-1:0] dest;
      logic               dir;
   } request_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STROBE = 2'd2,
      ST_GAP    = 2'd3
   } disp_state_e;

   function automatic logic travel_dir(input logic [FLOOR_W-1:0] src,
                                       input logic [FLOOR_W-1:0] dest);
      return (dest > src) ? DIR_UP : DIR_DOWN;
   endfunction

endpackage

// File: rtl/request_fifo.sv
// rtl/request_fifo.sv - synchronous request FIFO with count/full/empty
// and per-entry read ports (entry contents plus valid bits) for duplicate matching.
module request_fifo
   import elevator_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  request_t         push_data_i,
   input  logic             pop_i,
   output request_t         head_o,
   output logic [PTR_W:0]   count_o,
   output logic             full_o,
   output logic             empty_o,
   output request_t         entries_o [DEPTH],
   output logic [DEPTH-1:0] entry_valid_o
);

   request_t         mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      // Pointers are PTR_W bits wide, so the +1 wraps modulo DEPTH on its own.
      if (do_push) begin
         wr_ptr_d          = wr_ptr_q + 1'b1;
         valid_d[wr_ptr_q] = 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d          = rd_ptr_q + 1'b1;
         valid_d[rd_ptr_q] = 1'b0;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o        = mem_q[rd_ptr_q];
   assign count_o       = count_q;
   assign entries_o     = mem_q;
   assign entry_valid_o = valid_q;

endmodule

// File: rtl/request_dispatcher.sv
// rtl/request_dispatcher.sv - validates passenger requests, buffers them and dispatches one
// trip at a time with a set strobe; DISPATCH_DUP_FILTER_EN drops requests already buffered.
module request_dispatcher
   import elevator_pkg::*;
#(
   parameter  int NUM_FLOORS      = 8,
   parameter  int DEPTH           = 4,
   parameter  int MAX_OUTSTANDING = 2,
   localparam int CNT_W           = $clog2(DEPTH) + 1,
   localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   input  logic [FLOOR_W-1:0] req_src,
   input  logic [FLOOR_W-1:0] req_dest,
   output logic               req_ready,
   output logic               req_err,
   input  logic               trip_done,
   output logic [FLOOR_W-1:0] src_out,
   output logic [FLOOR_W-1:0] dest_out,
   output logic               direction_out,
   output logic               set_strobe,
   output logic [OUT_W-1:0]   outstanding,
   output logic [CNT_W-1:0]   fifo_count
);

   localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W+1)'(NUM_FLOORS);
   localparam logic [OUT_W-1:0] OUT_LIMIT   = OUT_W'(MAX_OUTSTANDING);

   disp_state_e        state_q, state_d;
   logic [OUT_W-1:0]   outstanding_q, outstanding_d;
   logic [FLOOR_W-1:0] src_q, src_d;
   logic [FLOOR_W-1:0] dest_q, dest_d;
   logic               dir_q, dir_d;
   logic               req_err_q, req_err_d;

   logic               accept;
   logic               illegal;
   logic               dup_hit;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic               strobe;
   request_t           push_data;
   request_t           head;

   assign accept  = req_valid && req_ready;
   assign illegal = (req_src == req_dest)
                 || ({1'b0, req_src}  >= FLOOR_LIMIT)
                 || ({1'b0, req_dest} >= FLOOR_LIMIT);

   assign push_data = '{src: req_src, dest: req_dest, dir: travel_dir(req_src, req_dest)};
   assign fifo_push = accept && !illegal && !dup_hit;

`ifdef DISPATCH_DUP_FILTER_EN
   request_t         fifo_entries [DEPTH];
   logic [DEPTH-1:0] fifo_entry_valid;

   always_comb begin
      dup_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_entry_valid[i]
             && fifo_entries[i].src == req_src
             && fifo_entries[i].dest == req_dest) begin
            dup_hit = 1'b1;
         end
      end
   end
`else
   assign dup_hit = 1'b0;
`endif

   request_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i         (clk),
      .rst_i         (rst),
      .push_i        (fifo_push),
      .push_data_i   (push_data),
      .pop_i         (fifo_pop),
      .head_o        (head),
      .count_o       (fifo_count),
      .full_o        (fifo_full),
      .empty_o       (fifo_empty),
`ifdef DISPATCH_DUP_FILTER_EN
      .entries_o     (fifo_entries),
      .entry_valid_o (fifo_entry_valid)
`else
      .entries_o     (),
      .entry_valid_o ()
`endif
   );

   assign req_ready = !fifo_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A push into an empty FIFO is looked ahead so LOAD follows the accept cycle directly.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if ((!fifo_empty || fifo_push) && (outstanding_q < OUT_LIMIT)) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD:   state_d = ST_STROBE;
         ST_STROBE: state_d = ST_GAP;
         ST_GAP:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fifo_pop = 1'b0;
      strobe   = 1'b0;
      case (state_q)
         ST_LOAD:   fifo_pop = 1'b1;
         ST_STROBE: strobe   = 1'b1;
         default: begin
            fifo_pop = 1'b0;
            strobe   = 1'b0;
         end
      endcase
   end

   always_comb begin
      src_d     = src_q;
      dest_d    = dest_q;
      dir_d     = dir_q;
      req_err_d = accept && illegal;
      if (fifo_pop) begin
         src_d  = head.src;
         dest_d = head.dest;
         dir_d  = head.dir;
      end
      outstanding_d = outstanding_q;
      if (strobe && !trip_done) begin
         outstanding_d = outstanding_q + 1'b1;
      end else if (!strobe && trip_done && (outstanding_q != '0)) begin
         outstanding_d = outstanding_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q         <= '0;
         dest_q        <= '0;
         dir_q         <= DIR_DOWN;
         req_err_q     <= 1'b0;
         outstanding_q <= '0;
      end else begin
         src_q         <= src_d;
         dest_q        <= dest_d;
         dir_q         <= dir_d;
         req_err_q     <= req_err_d;
         outstanding_q <= outstanding_d;
      end
   end

   // During LOAD the head is shown directly, so outputs settle a full cycle ahead of the strobe.
   assign src_out       = (state_q == ST_LOAD) ? head.src  : src_q;
   assign dest_out      = (state_q == ST_LOAD) ? head.dest : dest_q;
   assign direction_out = (state_q == ST_LOAD) ? head.dir  : dir_q;
   assign set_strobe    = strobe;
   assign req_err       = req_err_q;
   assign outstanding   = outstanding_q;

endmodule

// File: tb/tb_request_dispatcher.sv
// tb/tb_request_dispatcher.sv - directed self-checking bench for request_dispatcher
// (NUM_FLOORS=7 so floor 7 is illegal and floor 6 legal); honours DISPATCH_DUP_FILTER_EN.
module tb_request_dispatcher;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [2:0] req_src;
   logic [2:0] req_dest;
   logic       req_ready;
   logic       req_err;
   logic       trip_done;
   logic [2:0] src_out;
   logic [2:0] dest_out;
   logic       direction_out;
   logic       set_strobe;
   logic [1:0] outstanding;
   logic [2:0] fifo_count;

   int n_cmp = 0;
   int n_err = 0;

   request_dispatcher #(
      .NUM_FLOORS      (7),
      .DEPTH           (4),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_src       (req_src),
      .req_dest      (req_dest),
      .req_ready     (req_ready),
      .req_err       (req_err),
      .trip_done     (trip_done),
      .src_out       (src_out),
      .dest_out      (dest_out),
      .direction_out (direction_out),
      .set_strobe    (set_strobe),
      .outstanding   (outstanding),
      .fifo_count    (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive_req(input logic [2:0] s, input logic [2:0] d);
      req_valid = 1'b1;
      req_src   = s;
      req_dest  = d;
   endtask

   task automatic idle_req();
      req_valid = 1'b0;
      req_src   = '0;
      req_dest  = '0;
   endtask

   task automatic pulse_done();
      trip_done = 1'b1;
      cyc();
      trip_done = 1'b0;
   endtask

   // Two trips dispatched and not finished, so later pushes stay buffered.
   task automatic fill_outstanding();
      drive_req(3'd1, 3'd2);
      cyc();
      drive_req(3'd2, 3'd3);
      cyc();
      idle_req();
      repeat (12) cyc();
   endtask

   int         strobes;
   int         stb_cyc [2];
   logic [6:0] stb_val [2];
   logic       seen;

   initial begin
      rst       = 1'b1;
      trip_done = 1'b0;
      idle_req();
      cyc();
      cyc();
      check_eq("rst_strobe", set_strobe, 0);
      check_eq("rst_ready", req_ready, 1);
      check_eq("rst_count", fifo_count, 0);
      check_eq("rst_outstanding", outstanding, 0);
      check_eq("rst_src", src_out, 0);
      check_eq("rst_err", req_err, 0);
      rst = 1'b0;
      cyc();

      // 1: single request, strobe two cycles after acceptance
      drive_req(3'd1, 3'd5);
      cyc();
      idle_req();
      check_eq("t1_n1_strobe", set_strobe, 0);
      check_eq("t1_n1_count", fifo_count, 1);
      check_eq("t1_n1_src_setup", src_out, 1);
      check_eq("t1_n1_dest_setup", dest_out, 5);
      cyc();
      check_eq("t1_n2_strobe", set_strobe, 1);
      check_eq("t1_n2_src", src_out, 1);
      check_eq("t1_n2_dest", dest_out, 5);
      check_eq("t1_n2_dir", direction_out, 1);
      cyc();
      check_eq("t1_n3_strobe", set_strobe, 0);
      check_eq("t1_outstanding", outstanding, 1);
      check_eq("t1_count", fifo_count, 0);
      pulse_done();
      check_eq("t1_done_outstanding", outstanding, 0);

      // 2: illegal requests pulse req_err and never dispatch
      drive_req(3'd3, 3'd3);
      cyc();
      check_eq("t2_err_same", req_err, 1);
      check_eq("t2_count_a", fifo_count, 0);
      drive_req(3'd2, 3'd7);
      cyc();
      idle_req();
      check_eq("t2_err_range", req_err, 1);
      check_eq("t2_count_b", fifo_count, 0);
      cyc();
      check_eq("t2_err_clear", req_err, 0);
      strobes = 0;
      for (int k = 0; k < 8; k++) begin
         if (set_strobe) strobes++;
         cyc();
      end
      check_eq("t2_no_strobe", strobes, 0);

      // 3: three back-to-back requests, outstanding limit holds the third
      strobes = 0;
      for (int k = 0; k < 18; k++) begin
         if (set_strobe) begin
            if (strobes < 2) begin
               stb_cyc[strobes] = k;
               stb_val[strobes] = {src_out, dest_out, direction_out};
            end
            strobes++;
         end
         case (k)
            0:       drive_req(3'd0, 3'd4);
            1:       drive_req(3'd6, 3'd2);
            2:       drive_req(3'd5, 3'd1);
            default: idle_req();
         endcase
         cyc();
      end
      check_eq("t3_strobe_count", strobes, 2);
      check_eq("t3_first_cycle", stb_cyc[0], 2);
      check_eq("t3_spacing", stb_cyc[1] - stb_cyc[0], 4);
      check_eq("t3_first_req", stb_val[0], {3'd0, 3'd4, 1'b1});
      check_eq("t3_second_req", stb_val[1], {3'd6, 3'd2, 1'b0});
      check_eq("t3_outstanding_full", outstanding, 2);
      check_eq("t3_count_waiting", fifo_count, 1);
      pulse_done();
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (set_strobe) begin
            seen = 1'b1;
            check_eq("t3_rel_src", src_out, 5);
            check_eq("t3_rel_dest", dest_out, 1);
            check_eq("t3_rel_dir", direction_out, 0);
            pulse_done();
            check_eq("t3_done_with_strobe", outstanding, 1);
         end else begin
            cyc();
         end
      end
      check_eq("t3_release_seen", seen, 1);
      pulse_done();
      check_eq("t3_outstanding_zero", outstanding, 0);
      pulse_done();
      check_eq("t3_outstanding_sat", outstanding, 0);

      // 4: fill the FIFO while dispatch is blocked
      fill_outstanding();
      check_eq("t4_outstanding", outstanding, 2);
      drive_req(3'd0, 3'd1);
      cyc();
      drive_req(3'd1, 3'd0);
      cyc();
      drive_req(3'd3, 3'd4);
      cyc();
      drive_req(3'd4, 3'd3);
      cyc();
      check_eq("t4_count_full", fifo_count, 4);
      check_eq("t4_ready_low", req_ready, 0);
      drive_req(3'd5, 3'd6);
      cyc();
      idle_req();
      check_eq("t4_fifth_ignored", fifo_count, 4);
      check_eq("t4_fifth_no_err", req_err, 0);
      pulse_done();
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (req_ready) seen = 1'b1;
         else cyc();
      end
      check_eq("t4_ready_back", seen, 1);
      check_eq("t4_count_after_pop", fifo_count, 3);
      check_eq("t4_strobe_now", set_strobe, 1);
      check_eq("t4_fifo_order_src", src_out, 0);
      check_eq("t4_fifo_order_dest", dest_out, 1);

      // 5: reset in STROBE with three entries queued
      rst = 1'b1;
      #1;
      check_eq("t5_strobe", set_strobe, 0);
      check_eq("t5_count", fifo_count, 0);
      check_eq("t5_outstanding", outstanding, 0);
      check_eq("t5_outputs", {src_out, dest_out, direction_out}, 0);
      check_eq("t5_ready", req_ready, 1);
      cyc();
      rst = 1'b0;
      strobes = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (set_strobe) strobes++;
      end
      check_eq("t5_no_strobe", strobes, 0);

      // 6: duplicate request while the first is still buffered
      fill_outstanding();
      drive_req(3'd2, 3'd6);
      cyc();
      check_eq("t6_first_count", fifo_count, 1);
      cyc();
      idle_req();
      check_eq("t6_dup_no_err", req_err, 0);
`ifdef DISPATCH_DUP_FILTER_EN
      check_eq("t6_dup_count", fifo_count, 1);
`else
      check_eq("t6_dup_count", fifo_count, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
